// File: rtl/bsg_two_fifo_pkg.sv
// Shared constants and FSM state type for the two-entry FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bsg_two_fifo_pkg;

  localparam int fifo_width_c = 13;
  localparam int fifo_els_c   = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/bsg_mem_1r1w_width_p13_els_p2.sv
// Two-entry flop storage: one clocked write port, one asynchronous read port.
// Latency: write visible on the read port right after the write edge; read is combinational.
// Backpressure: none; the caller decides when to write.
module bsg_mem_1r1w_width_p13_els_p2
  import bsg_two_fifo_pkg::*;
#(
  parameter int width_p = fifo_width_c,
  parameter int els_p   = fifo_els_c,
  localparam int addr_w = $clog2(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               w_v_i,
  input  logic [addr_w-1:0]  w_addr_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic [addr_w-1:0]  r_addr_i,
  output logic [width_p-1:0] r_data_o
);

  logic [width_p-1:0] mem [els_p];

  // Entries clear on reset so the read port shows zero while the FIFO is reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) begin
        mem[i] <= '0;
      end
    end else if (w_v_i) begin
      mem[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bsg_two_fifo_width_p13.sv
// Two-entry valid/ready FIFO, 13-bit payload; optional sticky error flag under BSG_TWO_FIFO_ERR_EN.
// Latency: 1 cycle from enqueue edge to head on data_o; no bypass, no fall-through when full.
// Backpressure: ready_o drops when full or in reset; valid_i is ignored then and the producer holds.
module bsg_two_fifo_width_p13
  import bsg_two_fifo_pkg::*;
#(
  parameter int width_p = fifo_width_c,
  parameter int els_p   = fifo_els_c,
  localparam int ptr_w  = $clog2(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  input  logic               yumi_i,
  output logic               err_o
);

  state_e           state, state_next;
  logic [ptr_w-1:0] rptr, wptr;
  logic             enq, deq;

  assign ready_o = (state != FULL) & ~reset_i;
  assign valid_o = (state != EMPTY);

  // A yumi with nothing to take is dropped here so it never moves a pointer.
  assign enq = valid_i & ready_o;
  assign deq = yumi_i & valid_o;

  // Occupancy next-state; a simultaneous enq+deq in ONE stays in ONE.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (enq) state_next = ONE;
      ONE: begin
        if (enq && !deq)      state_next = FULL;
        else if (deq && !enq) state_next = EMPTY;
      end
      FULL:    if (deq) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // State and pointers; pointers wrap by toggling.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= EMPTY;
      rptr  <= '0;
      wptr  <= '0;
    end else begin
      state <= state_next;
      if (enq) wptr <= ~wptr;
      if (deq) rptr <= ~rptr;
    end
  end

  bsg_mem_1r1w_width_p13_els_p2 #(
    .width_p (width_p),
    .els_p   (els_p)
  ) u_mem (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .w_v_i    (enq),
    .w_addr_i (wptr),
    .w_data_i (data_i),
    .r_addr_i (rptr),
    .r_data_o (data_o)
  );

`ifdef BSG_TWO_FIFO_ERR_EN
  logic err_q;

  // Sticky flag for a consumer taking from an empty FIFO; only reset clears it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                err_q <= 1'b0;
    else if (yumi_i && !valid_o) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_two_fifo_width_p13.sv
// Directed table-driven bench for the two-entry FIFO plus async-reset sequence.
// Latency: expectations are sampled 1 time unit after each rising edge.
// Backpressure: rows exercise full, empty, illegal yumi and ignored valid_i.
module tb_bsg_two_fifo_width_p13;

  logic        clk_i;
  logic        reset_i;
  logic [12:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [12:0] data_o;
  logic        valid_o;
  logic        yumi_i;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef BSG_TWO_FIFO_ERR_EN
  localparam bit err_en = 1'b1;
`else
  localparam bit err_en = 1'b0;
`endif

  bsg_two_fifo_width_p13 dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .yumi_i  (yumi_i),
    .err_o   (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [12:0] d;
    logic        y;
    logic        ev;    // expected valid_o after the edge
    logic        er;    // expected ready_o after the edge
    logic [12:0] ed;    // expected data_o after the edge
    logic        cd;    // data_o compared only when set
    logic        es;    // an illegal yumi has happened by this edge
  } vec_t;

  localparam int n_vec = 17;
  vec_t tbl [n_vec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Post-edge expectations, hand-computed.
    tbl[0]  = '{1'b1, 13'h1ABC, 1'b0, 1'b1, 1'b1, 13'h1ABC, 1'b1, 1'b0}; // EMPTY->ONE
    tbl[1]  = '{1'b1, 13'h0123, 1'b0, 1'b1, 1'b0, 13'h1ABC, 1'b1, 1'b0}; // ONE->FULL
    tbl[2]  = '{1'b0, 13'h0000, 1'b1, 1'b1, 1'b1, 13'h0123, 1'b1, 1'b0}; // FULL->ONE
    tbl[3]  = '{1'b0, 13'h0000, 1'b1, 1'b0, 1'b1, 13'h0000, 1'b0, 1'b0}; // ONE->EMPTY
    tbl[4]  = '{1'b1, 13'h0001, 1'b0, 1'b1, 1'b1, 13'h0001, 1'b1, 1'b0}; // hold 0x0001
    tbl[5]  = '{1'b1, 13'h0002, 1'b1, 1'b1, 1'b1, 13'h0002, 1'b1, 1'b0}; // enq+deq in ONE
    tbl[6]  = '{1'b1, 13'h0003, 1'b1, 1'b1, 1'b1, 13'h0003, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 13'h0004, 1'b1, 1'b1, 1'b1, 13'h0004, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 13'h0005, 1'b1, 1'b1, 1'b1, 13'h0005, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 13'h0006, 1'b1, 1'b1, 1'b1, 13'h0006, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 13'h0007, 1'b1, 1'b1, 1'b1, 13'h0007, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 13'h0AAA, 1'b0, 1'b1, 1'b0, 13'h0007, 1'b1, 1'b0}; // ONE->FULL
    tbl[12] = '{1'b1, 13'h1FFF, 1'b1, 1'b1, 1'b1, 13'h0AAA, 1'b1, 1'b0}; // no fall-through
    tbl[13] = '{1'b0, 13'h0000, 1'b1, 1'b0, 1'b1, 13'h0000, 1'b0, 1'b0}; // 0x1FFF absent
    tbl[14] = '{1'b0, 13'h0000, 1'b1, 1'b0, 1'b1, 13'h0000, 1'b0, 1'b1}; // illegal yumi
    tbl[15] = '{1'b1, 13'h0555, 1'b0, 1'b1, 1'b1, 13'h0555, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 13'h0000, 1'b0, 1'b1, 1'b1, 13'h0555, 1'b1, 1'b1};

    reset_i = 1'b1;
    valid_i = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;

    // Outputs held quiet during reset, even with valid_i offered.
    @(posedge clk_i);
    valid_i = 1'b1;
    data_i  = 13'h0F0F;
    @(posedge clk_i);
    #1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_data",  32'(data_o),  32'd0);
    check("rst_err",   32'(err_o),   32'd0);

    @(negedge clk_i);
    reset_i = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    @(posedge clk_i);
    #1;
    check("idle_valid", 32'(valid_o), 32'd0);
    check("idle_ready", 32'(ready_o), 32'd1);
    check("idle_data",  32'(data_o),  32'd0);
    check("idle_err",   32'(err_o),   32'd0);

    for (int i = 0; i < n_vec; i++) begin
      @(negedge clk_i);
      valid_i = tbl[i].v;
      data_i  = tbl[i].d;
      yumi_i  = tbl[i].y;
      @(posedge clk_i);
      #1;
      check($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(tbl[i].ev));
      check($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(tbl[i].er));
      if (tbl[i].cd)
        check($sformatf("vec%0d_data", i), 32'(data_o), 32'(tbl[i].ed));
      check($sformatf("vec%0d_err", i), 32'(err_o), 32'(tbl[i].es & err_en));
    end

    // Fill to FULL (0x0555 already at head), then reset mid-cycle.
    @(negedge clk_i);
    valid_i = 1'b1;
    data_i  = 13'h0666;
    yumi_i  = 1'b0;
    @(posedge clk_i);
    #1;
    check("pre_rst_ready", 32'(ready_o), 32'd0);
    check("pre_rst_valid", 32'(valid_o), 32'd1);
    #2;
    reset_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 13'h1111;
    #1;
    check("async_rst_valid", 32'(valid_o), 32'd0);
    check("async_rst_ready", 32'(ready_o), 32'd0);
    check("async_rst_data",  32'(data_o),  32'd0);
    check("async_rst_err",   32'(err_o),   32'd0);
    @(posedge clk_i);
    #1;
    check("rst_edge_valid", 32'(valid_o), 32'd0);

    @(negedge clk_i);
    reset_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 13'h0ABC;
    #1;
    check("rel_ready", 32'(ready_o), 32'd1);
    check("rel_valid", 32'(valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("first_enq_valid", 32'(valid_o), 32'd1);
    check("first_enq_data",  32'(data_o),  32'h0ABC);
    check("first_enq_ready", 32'(ready_o), 32'd1);

    // Drain and confirm nothing stale survived the reset.
    @(negedge clk_i);
    valid_i = 1'b0;
    yumi_i  = 1'b1;
    @(posedge clk_i);
    #1;
    check("drain_valid", 32'(valid_o), 32'd0);
    check("drain_err",   32'(err_o),   32'd0);

    @(negedge clk_i);
    yumi_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
